// File: rtl/ps2_cmd_fifo.sv
// PS/2 keyboard receiver and scan-code decoder feeding a small command FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
module ps2_cmd_fifo #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        empty,
    output logic        overflow,
    output logic        frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    kclk_sync;
    logic [1:0]    kdat_sync;
    logic          kclk_prev;
    logic          fall;
    logic          bit_in;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          par_ok;
    logic          frame_ok;
    logic          frame_bad;

    logic          byte_vld;
    logic [7:0]    byte_q;
    logic          ext;
    logic          brk;
    logic [2:0]    cmd;
    logic          push;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            kclk_sync <= 2'b11;
            kdat_sync <= 2'b11;
            kclk_prev <= 1'b1;
        end else begin
            kclk_sync <= {kclk_sync[0], ps2_clk};
            kdat_sync <= {kdat_sync[0], ps2_data};
            kclk_prev <= kclk_sync[1];
        end
    end

    assign fall   = kclk_prev & ~kclk_sync[1];
    assign bit_in = kdat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shift, par};
`else
    logic par_unused;
    assign par_unused = par;
    assign par_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tmo     <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par     <= par_n;
            tmo     <= tmo_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        tmo_n     = '0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (state != IDLE && !fall) begin
            tmo_n = tmo + 1'b1;
        end
        // A stalled partial frame is dropped silently
        if (state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            shift_n   = '0;
            tmo_n     = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {bit_in, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = bit_in;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (bit_in && par_ok) frame_ok  = 1'b1;
                    else                  frame_bad = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= frame_ok;
            frame_err <= frame_bad;
            if (frame_ok) byte_q <= shift;
            if (frame_bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_vld) begin
                case (byte_q)
                    8'hE0:   ext <= 1'b1;
                    8'hF0:   brk <= 1'b1;
                    default: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cmd = 3'd0;
        if (!brk) begin
            if (ext) begin
                case (byte_q)
                    8'h6B:   cmd = 3'd1;
                    8'h74:   cmd = 3'd2;
                    8'h75:   cmd = 3'd3;
                    8'h72:   cmd = 3'd4;
                    default: cmd = 3'd0;
                endcase
            end else if (byte_q == 8'h29) begin
                cmd = 3'd5;
            end
        end
    end

    assign push    = byte_vld && (cmd != 3'd0);
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // A pop on the same edge frees the slot for a push while full
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    assign rd_data = empty ? 32'd0 : {29'd0, mem[rd_ptr]};

endmodule

// File: tb/tb_ps2_cmd_fifo.sv
// Directed bench for ps2_cmd_fifo: scan-code table plus FIFO,
// timeout, parity and reset corner sequences.
module tb_ps2_cmd_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int HALF  = 8;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic        overflow;
    logic        frame_err;

    int checks;
    int errors;
    int ferr_cnt;

    typedef struct {
        int          n;
        logic [23:0] seq;
        logic [2:0]  cmd;
    } vec_t;

    vec_t vt[13];

    ps2_cmd_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic frame_head(input logic [7:0] v, input logic badpar);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i]);
        ps2_bit((~^v) ^ badpar);
    endtask

    task automatic stop_fall(input logic sb);
        ps2_data = sb;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic stop_rise(input int used);
        repeat (HALF - used) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] v);
        frame_head(v, 1'b0);
        stop_fall(1'b1);
        stop_rise(0);
    endtask

    // rd_en lands on the same edge as the push
    task automatic send_frame_pop(input logic [7:0] v);
        frame_head(v, 1'b0);
        stop_fall(1'b1);
        repeat (3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        stop_rise(4);
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        @(negedge clk);
        chk(nm, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int f0;
        checks   = 0;
        errors   = 0;
        ferr_cnt = 0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        reset    = 1'b1;

        vt[0]  = '{2, 24'hE06B00, 3'd1};
        vt[1]  = '{2, 24'hE07400, 3'd2};
        vt[2]  = '{2, 24'hE07500, 3'd3};
        vt[3]  = '{2, 24'hE07200, 3'd4};
        vt[4]  = '{1, 24'h290000, 3'd5};
        vt[5]  = '{3, 24'hE0F074, 3'd0};
        vt[6]  = '{1, 24'h290000, 3'd5};
        vt[7]  = '{2, 24'hF02900, 3'd0};
        vt[8]  = '{2, 24'hE02900, 3'd0};
        vt[9]  = '{1, 24'h6B0000, 3'd0};
        vt[10] = '{1, 24'h1C0000, 3'd0};
        vt[11] = '{3, 24'hE0E075, 3'd3};
        vt[12] = '{3, 24'hF0E06B, 3'd0};

        repeat (3) @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Push lands one cycle after the edge that takes the stop bit
        send_frame(8'hE0);
        frame_head(8'h6B, 1'b0);
        stop_fall(1'b1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (!empty) begin
                k = i;
                break;
            end
        end
        chk("stop_to_empty_cycles", k, 4);
        stop_rise(0);
        chk("left_rd_data", rd_data, 32'd1);
        pop_chk("left_pop", 32'd1);
        chk("left_empty_after", {31'd0, empty}, 32'd1);
        chk("left_rd_zero", rd_data, 32'd0);

        for (int v = 0; v < 13; v++) begin
            for (int j = 0; j < vt[v].n; j++) begin
                send_frame(vt[v].seq[23 - 8*j -: 8]);
            end
            chk($sformatf("vec%0d_empty", v), {31'd0, empty},
                {31'd0, vt[v].cmd == 3'd0});
            chk($sformatf("vec%0d_rd", v), rd_data, {29'd0, vt[v].cmd});
            if (vt[v].cmd != 3'd0) begin
                pop_chk($sformatf("vec%0d_pop", v), {29'd0, vt[v].cmd});
                chk($sformatf("vec%0d_drained", v), {31'd0, empty}, 32'd1);
            end
        end

        // Push with rd_en on an empty FIFO: pop ignored
        send_frame_pop(8'h29);
        chk("pe_empty", {31'd0, empty}, 32'd0);
        chk("pe_rd", rd_data, 32'd5);
        for (int i = 0; i < 7; i++) send_frame(8'h29);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        // Push and pop together while full
        send_frame(8'hE0);
        send_frame_pop(8'h6B);
        chk("pf_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 7; i++) pop_chk("pf_pop5", 32'd5);
        pop_chk("pf_pop1", 32'd1);
        chk("pf_empty", {31'd0, empty}, 32'd1);

        for (int i = 0; i < 9; i++) send_frame(8'h29);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("ovf_pop", 32'd5);
        chk("ovf_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("pop_empty_ignored", {31'd0, empty}, 32'd1);
        do_reset();
        chk("ovf_reset", {31'd0, overflow}, 32'd0);

        // Bad parity
        f0 = ferr_cnt;
        frame_head(8'h29, 1'b1);
        stop_fall(1'b1);
        stop_rise(0);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_ferr", ferr_cnt - f0, 1);
        chk("par_empty", {31'd0, empty}, 32'd1);
`else
        chk("par_ferr", ferr_cnt - f0, 0);
        chk("par_empty", {31'd0, empty}, 32'd0);
        pop_chk("par_pop", 32'd5);
`endif

        // Bad stop bit rejects the frame and clears the ext prefix
        send_frame(8'hE0);
        f0 = ferr_cnt;
        frame_head(8'h11, 1'b0);
        stop_fall(1'b0);
        stop_rise(0);
        chk("stop_ferr", ferr_cnt - f0, 1);
        send_frame(8'h6B);
        chk("stop_prefix_clr", {31'd0, empty}, 32'd1);

        // Stalled partial frame times out silently
        f0 = ferr_cnt;
        ps2_data = 1'b1;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        repeat (TMO + 40) @(negedge clk);
        chk("tmo_ferr", ferr_cnt - f0, 0);
        send_frame(8'h29);
        chk("tmo_rd", rd_data, 32'd5);
        pop_chk("tmo_pop", 32'd5);

        // Reset mid-frame with three queued commands
        for (int i = 0; i < 3; i++) send_frame(8'h29);
        chk("mid_queued", {31'd0, empty}, 32'd0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        do_reset();
        chk("mid_empty", {31'd0, empty}, 32'd1);
        chk("mid_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_rd", rd_data, 32'd0);
        f0 = ferr_cnt;
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        chk("mid_no_push", {31'd0, empty}, 32'd1);
        chk("mid_no_ferr", ferr_cnt - f0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_fifo.md
PS2_CMD_FIFO -- requirements
Module: ps2_cmd_fifo

Interface
REQ-001 Parameter DEPTH, 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  asynchronous PS/2 clock line from the keyboard.
REQ-006 ps2_data  input  1  asynchronous PS/2 data line from the keyboard.
REQ-007 rd_en  input  1  processor load strobe that pops one command.
REQ-008 rd_data  output  32  {29'b0, head command}; SHALL be 0 when empty.
REQ-009 empty  output  1  high when the FIFO holds no commands.
REQ-010 overflow  output  1  sticky; set when a command is dropped because the FIFO is full.
REQ-011 frame_err  output  1  one-cycle pulse per rejected frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synced ps2_clk previous=1, current=0.
REQ-013 Receiver FSM states IDLE, DATA, PARITY, STOP; all bit sampling SHALL occur only on a detected falling edge.
REQ-014 IDLE: edge with data=0 -> DATA, bit count 0; edge with data=1 -> stays IDLE, no error.
REQ-015 DATA: shift data in LSB first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture parity bit -> STOP.
REQ-017 STOP: capture stop bit -> IDLE; frame is valid if stop=1 (plus the parity rule of REQ-027/028); an invalid frame pulses frame_err on the following cycle and clears the prefix flags.
REQ-018 A non-IDLE state with no falling edge for TIMEOUT_CYCLES consecutive cycles SHALL return to IDLE, discard the partial byte, and not pulse frame_err.
REQ-019 Decoder on each valid byte: 0xE0 sets ext flag; 0xF0 sets brk flag; any other byte is decoded and then both flags clear.
REQ-020 Make codes (brk=0) map: ext 0x6B -> 1 (left), ext 0x74 -> 2 (right), ext 0x75 -> 3 (rotate), ext 0x72 -> 4 (soft drop), non-ext 0x29 -> 5 (hard drop); break codes and unmapped codes push nothing.
REQ-021 A mapped command SHALL be written at the rising edge after the edge that accepted the stop bit; empty SHALL fall at that edge.
REQ-022 rd_en with empty=0 pops the head at that edge; rd_en with empty=1 is ignored with no state change.
REQ-023 Push while full without a pop: command dropped and overflow set; push and pop at the same edge while full: both occur, count unchanged, overflow unaffected.
REQ-024 Push and rd_en at the same edge while empty: push occurs, pop ignored, count becomes 1.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-026 At a rising edge with reset=1: FSM IDLE, bit count 0, shift register 0, ext/brk cleared, timeout counter 0, pointers and count 0, empty=1, rd_data=0, overflow=0, frame_err=0, synchronizers loaded with 1; this SHALL abort any in-flight frame without a push.

Configuration
REQ-027 With PS2_PARITY_CHECK_EN defined: a frame is valid only if the 8 data bits plus the parity bit have odd parity and stop=1; otherwise frame_err pulses.
REQ-028 Without PS2_PARITY_CHECK_EN: the parity bit is captured but ignored; only stop=1 is required.

Verification
REQ-029 Frames E0, 6B (valid parity, stop=1) -> empty falls one cycle after the stop edge; rd_data=1; a single rd_en -> empty=1, rd_data=0.
REQ-030 Frames E0, F0, 74 followed by frame 29 -> exactly one entry, rd_data=5; no command 2 is ever pushed.
REQ-031 Nine 0x29 frames with DEPTH=8 and no reads -> count 8, overflow=1; eight pops return 5 each, then empty=1; overflow stays 1 until reset.
REQ-032 Frame 0x29 with a corrupted parity bit -> with macro: frame_err pulses once and no push; without macro: push of 5 and no frame_err.
REQ-033 Start bit plus 4 data bits then idle for TIMEOUT_CYCLES -> FSM back in IDLE with no frame_err; a following 0x29 frame pushes 5.
REQ-034 reset asserted for one cycle mid-frame while 3 commands are queued -> empty=1, overflow=0, rd_data=0; the rest of the interrupted frame pushes nothing.
